// File: rtl/pwm_commit_scheduler_if.sv
// Command port of the PWM commit scheduler: duty writes plus commit flag.
// Master is the command decoder, slave is the scheduler.
interface pwm_commit_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [CHW-1:0] cmd_ch;
    logic [CW-1:0]  cmd_duty;
    logic           cmd_commit;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_duty,
        output cmd_commit,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_duty,
        input  cmd_commit,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_commit_scheduler.sv
// Multi-channel PWM with shared counter and double-buffered duty/period.
// PWM_SYNC_COMMIT_EN: commits wait for the period boundary (else immediate).
module pwm_commit_scheduler #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [CW-1:0]         period,
    pwm_commit_scheduler_if.slave cmd,
    output logic                  busy,
    output logic                  wrap,
    output logic [CW-1:0]         cnt,
    output logic [NCH-1:0]        pwm_out
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_act_q, period_act_d;
    logic [CW-1:0] duty_sh_q [NCH];
    logic [CW-1:0] duty_sh_d [NCH];
    logic [CW-1:0] duty_act_q [NCH];
    logic [CW-1:0] duty_act_d [NCH];
    logic          xfer;

`ifdef PWM_SYNC_COMMIT_EN
    typedef enum logic {LOAD, ARMED} state_t;
    state_t state_q, state_d;
    logic   ready_q, ready_d;
    logic   busy_q, busy_d;
`else
    logic   unused_commit;
    assign unused_commit = cmd.cmd_commit;
`endif

    assign wrap = ena && (cnt_q == period_act_q);
    assign cnt  = cnt_q;

`ifdef PWM_SYNC_COMMIT_EN
    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
`else
    assign cmd.cmd_ready = 1'b1;
    assign busy          = 1'b0;
`endif

    assign xfer = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pwm_out[i] = ena && (cnt_q < duty_act_q[i]);
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        period_act_d = period_act_q;
        duty_sh_d    = duty_sh_q;
        duty_act_d   = duty_act_q;
        if (ena) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        // Out-of-range channel numbers match no slot and are dropped
        for (int i = 0; i < NCH; i++) begin
            if (xfer && (cmd.cmd_ch == CHW'(i))) begin
                duty_sh_d[i] = cmd.cmd_duty;
`ifndef PWM_SYNC_COMMIT_EN
                duty_act_d[i] = cmd.cmd_duty;
`endif
            end
        end
`ifdef PWM_SYNC_COMMIT_EN
        state_d = state_q;
        unique case (1'b1)
            (state_q == LOAD): begin
                if (xfer && cmd.cmd_commit) begin
                    state_d = ARMED;
                end
            end
            (state_q == ARMED): begin
                if (wrap) begin
                    state_d      = LOAD;
                    duty_act_d   = duty_sh_q;
                    period_act_d = period;
                end
            end
            default: state_d = LOAD;
        endcase
        ready_d = (state_d == LOAD);
        busy_d  = (state_d == ARMED);
`else
        if (wrap) begin
            period_act_d = period;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            period_act_q <= period;
            for (int i = 0; i < NCH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
`ifdef PWM_SYNC_COMMIT_EN
            state_q <= LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
`ifdef PWM_SYNC_COMMIT_EN
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`endif
        end
    end
endmodule
